// File: rtl/keyed_mux_pkg.sv
// Shared types and helpers for the keyed selector bank and its channels.
package keyed_mux_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int res;
    res = 0;
    while ((1 << res) < value) res++;
    return (res < 1) ? 1 : res;
  endfunction

  function automatic int ncand_of(input int selw);
    return 1 << selw;
  endfunction

  function automatic int keylen_of(input int nch, input int selw);
    return nch * selw;
  endfunction

  // Geometry of the default two-channel, 2-bit-key bank.
  localparam int NCAND  = ncand_of(2);
  localparam int KEYLEN = keylen_of(2, 2);

endpackage

// File: rtl/keyed_mux_chan.sv
// One keyed selector: registers the candidate picked by sel, or the lock value.
module keyed_mux_chan #(
  parameter int SELW = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    lock,
  input  logic                    lock_val,
  input  logic [SELW-1:0]         sel,
  input  logic [(1 << SELW)-1:0]  cand,
  output logic                    q
);

  // lock_val is tied to a constant at the top, so the reset value is static.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= lock_val;
    end else if (lock) begin
      q <= lock_val;
    end else if (en) begin
      q <= cand[sel];
    end
  end

endmodule

// File: rtl/keyed_mux_bank.sv
// Bank of NCH keyed selectors whose key is shifted in serially and committed once complete.
module keyed_mux_bank
  import keyed_mux_pkg::*;
#(
  parameter int             NCH      = 2,
  parameter int             SELW     = 2,
  parameter logic [NCH-1:0] LOCK_VAL = '0,
  localparam int            NCANDL   = ncand_of(SELW),
  localparam int            KEYLENL  = keylen_of(NCH, SELW),
  localparam int            CNTW     = clog2(KEYLENL + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    key_in,
  input  logic                    key_valid,
  output logic                    key_ready,
  input  logic                    key_clear,
  input  logic                    din_valid,
  input  logic [NCH*NCANDL-1:0]   cand_in,
  output logic [NCH-1:0]          mux_out,
  output logic                    dout_valid,
  output logic                    locked,
  output logic [CNTW-1:0]         key_cnt
);

  state_t              state;
  logic [KEYLENL-1:0]  shift_q;
  logic [KEYLENL-1:0]  key_q;
  logic [KEYLENL-1:0]  shift_nxt;
  logic                accept;
  logic                last_bit;
  logic                active;

  assign active    = (state == ST_ACTIVE);
  assign key_ready = !active;
  assign locked    = !active;
  assign accept    = key_valid & key_ready & ~key_clear;
  assign last_bit  = (key_cnt == CNTW'(KEYLENL - 1));

  // First accepted bit migrates down to bit 0 once the whole key is in.
  generate
    if (KEYLENL == 1) begin : g_shift_one
      assign shift_nxt = key_in;
    end else begin : g_shift_many
      assign shift_nxt = {key_in, shift_q[KEYLENL-1:1]};
    end
  endgenerate

  // ---- key load stage: FSM, shift register, counter ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      shift_q <= '0;
      key_q   <= '0;
      key_cnt <= '0;
    end else if (key_clear) begin
      state   <= ST_IDLE;
      shift_q <= '0;
      key_q   <= '0;
      key_cnt <= '0;
    end else if (accept) begin
      shift_q <= shift_nxt;
      if (last_bit) begin
        state   <= ST_ACTIVE;
        key_q   <= shift_nxt;
        key_cnt <= CNTW'(KEYLENL);
      end else begin
        state   <= ST_LOAD;
        key_cnt <= key_cnt + 1'b1;
      end
    end
  end

  // ---- output stage: uses the pre-edge state, one cycle latency ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= active & din_valid;
    end
  end

  generate
    for (genvar c = 0; c < NCH; c++) begin : g_chan
      keyed_mux_chan #(
        .SELW (SELW)
      ) u_chan (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (active & din_valid),
        .lock     (!active),
        .lock_val (LOCK_VAL[c]),
        .sel      (key_q[c*SELW +: SELW]),
        .cand     (cand_in[c*NCANDL +: NCANDL]),
        .q        (mux_out[c])
      );
    end
  endgenerate

endmodule

// File: tb/tb_keyed_mux_bank.sv
// Directed bench for keyed_mux_bank with a per-cycle reference model and literal checkpoints.
module tb_keyed_mux_bank;

  localparam int             NCH      = 2;
  localparam int             SELW     = 2;
  localparam int             NCAND    = 1 << SELW;
  localparam int             KEYLEN   = NCH * SELW;
  localparam int             CNTW     = 3;
  localparam logic [NCH-1:0] LOCK_VAL = 2'b00;

  logic                   clk;
  logic                   rst_n;
  logic                   key_in;
  logic                   key_valid;
  logic                   key_ready;
  logic                   key_clear;
  logic                   din_valid;
  logic [NCH*NCAND-1:0]   cand_in;
  logic [NCH-1:0]         mux_out;
  logic                   dout_valid;
  logic                   locked;
  logic [CNTW-1:0]        key_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  keyed_mux_bank #(
    .NCH      (NCH),
    .SELW     (SELW),
    .LOCK_VAL (LOCK_VAL)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_in     (key_in),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .key_clear  (key_clear),
    .din_valid  (din_valid),
    .cand_in    (cand_in),
    .mux_out    (mux_out),
    .dout_valid (dout_valid),
    .locked     (locked),
    .key_cnt    (key_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: accepted key bits stored by arrival index.
  int               m_cnt;
  logic [KEYLEN-1:0] m_bits;
  bit               m_active;
  logic [NCH-1:0]   exp_mux;
  bit               exp_dv;

  function automatic logic [NCH-1:0] pick(input logic [KEYLEN-1:0] key,
                                          input logic [NCH*NCAND-1:0] cand);
    logic [NCH-1:0] r;
    int sel;
    for (int c = 0; c < NCH; c++) begin
      sel = 0;
      for (int b = 0; b < SELW; b++) sel += int'(key[c*SELW + b]) << b;
      r[c] = cand[c*NCAND + sel];
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt    <= 0;
      m_bits   <= '0;
      m_active <= 1'b0;
      exp_mux  <= LOCK_VAL;
      exp_dv   <= 1'b0;
    end else begin
      if (m_active && din_valid) begin
        exp_mux <= pick(m_bits, cand_in);
        exp_dv  <= 1'b1;
      end else if (m_active) begin
        exp_dv  <= 1'b0;
      end else begin
        exp_mux <= LOCK_VAL;
        exp_dv  <= 1'b0;
      end
      if (key_clear) begin
        m_cnt    <= 0;
        m_bits   <= '0;
        m_active <= 1'b0;
      end else if (key_valid && !m_active) begin
        m_bits[m_cnt] <= key_in;
        m_cnt         <= m_cnt + 1;
        m_active      <= (m_cnt + 1 == KEYLEN);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      check("model_mux_out",    32'(mux_out),    32'(exp_mux));
      check("model_dout_valid", 32'(dout_valid), 32'(exp_dv));
      check("model_locked",     32'(locked),     32'(!m_active));
      check("model_key_ready",  32'(key_ready),  32'(!m_active));
      check("model_key_cnt",    32'(key_cnt),    32'(m_cnt));
    end
  end

  task automatic send_bit(input logic b);
    @(negedge clk);
    key_valid = 1'b1;
    key_in    = b;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    logic [3:0] key_a;
    rst_n     = 1'b0;
    key_in    = 1'b0;
    key_valid = 1'b1;
    key_clear = 1'b0;
    din_valid = 1'b1;
    cand_in   = 8'hFF;
    idle_cycles(3);
    check("reset_mux_out",    32'(mux_out),    32'h0);
    check("reset_dout_valid", 32'(dout_valid), 32'h0);
    check("reset_locked",     32'(locked),     32'h1);
    check("reset_key_ready",  32'(key_ready),  32'h1);
    check("reset_key_cnt",    32'(key_cnt),    32'h0);
    key_valid = 1'b0;
    rst_n     = 1'b1;
    idle_cycles(3);
    check("idle_mux_locked", 32'(mux_out), 32'h0);

    // Load 1,0,1,1.
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    @(negedge clk);
    key_valid = 1'b0;
    check("load_key_cnt",   32'(key_cnt),   32'd4);
    check("load_locked",    32'(locked),    32'h0);
    check("load_key_ready", 32'(key_ready), 32'h0);
    check("load_key_q",     32'(dut.key_q), 32'b1101);
    check("model_key_bits", 32'(m_bits),    32'b1101);
    check("commit_no_dv",   32'(dout_valid), 32'h0);
    cand_in = 8'b1000_0010;
    @(negedge clk);
    check("active_mux_11", 32'(mux_out),    32'b11);
    check("active_dv",     32'(dout_valid), 32'h1);
    cand_in = 8'h00;
    @(negedge clk);
    check("active_mux_00", 32'(mux_out), 32'b00);
    din_valid = 1'b0;
    cand_in   = 8'hFF;
    @(negedge clk);
    check("hold_mux_00", 32'(mux_out),    32'b00);
    check("hold_dv",     32'(dout_valid), 32'h0);
    din_valid = 1'b1;
    cand_in   = 8'b1000_0010;

    // key_valid held in ACTIVE must not disturb anything.
    key_valid = 1'b1;
    key_in    = 1'b0;
    idle_cycles(10);
    key_valid = 1'b0;
    check("ignore_key_cnt", 32'(key_cnt),   32'd4);
    check("ignore_key_q",   32'(dut.key_q), 32'b1101);
    check("ignore_mux",     32'(mux_out),   32'b11);

    // Clear from ACTIVE: that edge still produces an ACTIVE output.
    key_clear = 1'b1;
    @(negedge clk);
    key_clear = 1'b0;
    check("clr_locked",  32'(locked),     32'h1);
    check("clr_key_cnt", 32'(key_cnt),    32'h0);
    check("clr_last_mux", 32'(mux_out),   32'b11);
    check("clr_last_dv", 32'(dout_valid), 32'h1);
    @(negedge clk);
    check("clr_lock_mux", 32'(mux_out),    32'b00);
    check("clr_lock_dv",  32'(dout_valid), 32'h0);

    // Clear together with a key bit mid-load.
    send_bit(1'b1);
    send_bit(1'b1);
    @(negedge clk);
    check("midload_cnt", 32'(key_cnt), 32'd2);
    key_clear = 1'b1;
    key_valid = 1'b1;
    key_in    = 1'b1;
    @(negedge clk);
    key_clear = 1'b0;
    key_valid = 1'b0;
    check("drop_key_cnt", 32'(key_cnt), 32'h0);
    check("drop_locked",  32'(locked),  32'h1);
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    @(negedge clk);
    key_valid = 1'b0;
    cand_in   = 8'h11;
    @(negedge clk);
    check("sel0_mux", 32'(mux_out), 32'b11);
    cand_in = 8'hEE;
    @(negedge clk);
    check("sel0_mux_inv", 32'(mux_out), 32'b00);

    // Second key 0,1,1,0: ch0 sel=2, ch1 sel=1; sweep candidates against the model.
    key_clear = 1'b1;
    @(negedge clk);
    key_clear = 1'b0;
    key_a = 4'b0110;
    for (int i = 0; i < 4; i++) send_bit(key_a[i]);
    @(negedge clk);
    key_valid = 1'b0;
    cand_in   = 8'b0010_0100;
    @(negedge clk);
    check("key2_mux_11", 32'(mux_out), 32'b11);
    for (int i = 0; i < 16; i++) begin
      cand_in   = 8'(i * 37 + 5);
      din_valid = (i % 3) != 0;
      @(negedge clk);
    end
    din_valid = 1'b1;
    cand_in   = 8'b0010_0100;
    @(negedge clk);

    // Asynchronous reset mid-cycle while ACTIVE.
    check("pre_rst_dv", 32'(dout_valid), 32'h1);
    #2;
    rst_n     = 1'b0;
    key_valid = 1'b1;
    #1;
    check("arst_mux_out",   32'(mux_out),    32'h0);
    check("arst_dout_valid", 32'(dout_valid), 32'h0);
    check("arst_locked",    32'(locked),     32'h1);
    check("arst_key_ready", 32'(key_ready),  32'h1);
    check("arst_key_cnt",   32'(key_cnt),    32'h0);
    idle_cycles(3);
    key_valid = 1'b0;
    rst_n     = 1'b1;
    idle_cycles(2);
    check("post_rst_key_cnt", 32'(key_cnt), 32'h0);
    check("post_rst_key_q",   32'(dut.key_q), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/keyed_mux_bank.md
Name: keyed_mux_bank

Overview:
- Parametrised, sequential successor to the team's key-controlled obfuscation muxes in the locked ISCAS netlists.
- Holds NCH independent keyed selectors. Each channel picks one of 2**SELW candidate wires using a key field.
- The key is loaded serially through a valid/ready handshake. Selector outputs are registered and forced to a safe constant until a full key has been committed.
- Sits between the circuit's candidate nets and the downstream logic that the fixed 2-bit key muxes used to feed.

Parameters:
- NCH, 2, number of keyed selector channels (1..32)
- SELW, 2, key bits per channel; each channel has NCAND = 2**SELW candidates (1..4)
- LOCK_VAL, 0, value (NCH bits) driven on mux_out while not ACTIVE
- Derived: KEYLEN = NCH*SELW; CNTW = clog2(KEYLEN+1)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- key_in  in  1  serial key bit
- key_valid  in  1  key_in is valid this cycle
- key_ready  out  1  bank accepts a key bit this cycle
- key_clear  in  1  synchronous request to discard the key and relock
- din_valid  in  1  cand_in is valid this cycle
- cand_in  in  NCH*NCAND  candidates; channel c uses cand_in[c*NCAND +: NCAND]
- mux_out  out  NCH  registered selector outputs
- dout_valid  out  1  mux_out is valid
- locked  out  1  high whenever state != ACTIVE
- key_cnt  out  CNTW  number of key bits accepted so far

Behaviour:
- Reset (rst_n low, asynchronous) sets:
  - state = IDLE; shift_q = 0; key_q = 0; key_cnt = 0
  - mux_out = LOCK_VAL; dout_valid = 0; locked = 1; key_ready = 1
- States:
  - IDLE (no bits taken)
  - LOAD (0 < key_cnt < KEYLEN)
  - ACTIVE (key committed)
- key_ready = 1 in IDLE and LOAD, 0 in ACTIVE. A bit is accepted when key_valid & key_ready & !key_clear.
- Shift rule: on accept, shift_q <= {key_in, shift_q[KEYLEN-1:1]} and key_cnt increments. The first accepted bit therefore ends up in bit 0 after KEYLEN accepts.
- IDLE -> LOAD on the first accept (KEYLEN > 1). If KEYLEN == 1, go directly to ACTIVE.
- LOAD -> ACTIVE on the accept that makes key_cnt reach KEYLEN. In that same edge, key_q <= the shifted value, and key_cnt holds KEYLEN.
- ACTIVE holds until key_clear. key_valid in ACTIVE is ignored (no shift, no count).
- key_clear in any state:
  - next edge: state = IDLE; shift_q = 0; key_q = 0; key_cnt = 0
  - key_clear wins over a simultaneous key_valid; that bit is dropped.
- Selection: sel_c = key_q[c*SELW +: SELW].
- Output register, one cycle latency:
  - ACTIVE and din_valid: mux_out[c] <= cand_in[c*NCAND + sel_c]; dout_valid <= 1.
  - ACTIVE and !din_valid: mux_out holds; dout_valid <= 0.
  - Not ACTIVE: mux_out <= LOCK_VAL; dout_valid <= 0.
- The state used for the output register is the current (pre-edge) state. The first valid output appears the cycle after ACTIVE is entered, never on the commit edge itself.
- key_clear while ACTIVE: the output stage still uses ACTIVE on that edge. From the following edge it drives LOCK_VAL.
- Reset mid-load or mid-stream: everything returns to reset values immediately; partial keys are never retained.
- key_valid X or high during reset: ignored.

Decomposition:
- Package keyed_mux_pkg:
  - state enum (IDLE, LOAD, ACTIVE)
  - clog2 helper function
  - localparams NCAND and KEYLEN, derived from NCH/SELW
- Sub-module keyed_mux_chan, instantiated NCH times via generate:
  - parameter SELW
  - inputs: clk, rst_n, en (= ACTIVE & din_valid), lock (= !ACTIVE), lock_val, sel, cand
  - output: one registered bit
- Top holds the FSM, the shift register, the counter and the dout_valid register.

Test Plan:
- Reset then idle, din_valid=1, cand_in=8'hFF, NCH=2, SELW=2, LOCK_VAL=0 -> mux_out=2'b00, dout_valid=0, locked=1, key_ready=1.
- Load bits 1,0,1,1 on four consecutive cycles -> key_cnt 1,2,3,4; locked falls on the 4th edge; key_q=4'b1101 (ch0 sel=1, ch1 sel=3); key_ready=0.
- ACTIVE with cand_in=8'b1000_0010 and din_valid=1 -> next cycle mux_out=2'b11, dout_valid=1. Then cand_in=8'b0000_0000 -> mux_out=2'b00 one cycle later.
- Mid-load after 2 bits, assert key_clear together with key_valid -> key_cnt=0, state IDLE, bit dropped. Reload 0,0,0,0 -> sel 0 on both channels; cand_in=8'h11 -> mux_out=2'b11.
- Drop rst_n asynchronously mid-cycle in ACTIVE -> mux_out=LOCK_VAL, dout_valid=0, locked=1 immediately, before the next clock edge.
- Keep key_valid=1 in ACTIVE for 10 cycles -> key_cnt stays 4, key_q unchanged, outputs unaffected.
